// File: rtl/regwin_pkg.sv
// Shared types and constants for the register-window controller.
package regwin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WIN    = 3'd1,
    ST_SPILL0 = 3'd2,
    ST_SPILL1 = 3'd3,
    ST_FILL0  = 3'd4,
    ST_FILL1  = 3'd5
  } state_t;

  localparam int unsigned NWIN_PAIRS   = 4;
  localparam logic [1:0]  SPILL_LO_REG = 2'd2;
  localparam logic [1:0]  FILL_LO_REG  = 2'd0;

endpackage

// File: rtl/reg_window_ctrl.sv
// Window-pointer manager for the 8x16 windowed register file: turns call/return
// pulses into window switches and spills/fills pairs to a memory stack.
module reg_window_ctrl
  import regwin_pkg::*;
#(
  parameter logic [15:0] STACK_BASE = 16'hFF00,
  parameter int unsigned MAX_SPILL  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        call_req,
  input  logic        ret_req,
  output logic [1:0]  in_wnd,
  output logic        change_wnd,
  output logic        stall,
  output logic [1:0]  rf_rd_reg,
  input  logic [15:0] rf_rd_data,
  output logic [1:0]  rf_wr_reg,
  output logic [15:0] rf_wr_data,
  output logic        rf_wr_en,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err
);

  localparam int unsigned CW    = $clog2(MAX_SPILL + 1);
  localparam logic [1:0]  K_MAX = 2'(NWIN_PAIRS - 1);

  state_t          r_state;
  logic [1:0]      r_cwp;
  logic [1:0]      r_k;
  logic [15:0]     r_sp;
  logic [CW-1:0]   r_spill_cnt;
  logic            r_need_spill;
  logic            r_need_fill;
  logic            r_err;

  logic            w_idle;
  logic            w_call_ok;
  logic            w_ret_ok;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_call_ok = call_req & ~ret_req & ~((r_k == K_MAX) && (r_spill_cnt == CW'(MAX_SPILL)));
  assign w_ret_ok  = ret_req & ~call_req & ~((r_k == 2'd1) && (r_spill_cnt == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cwp        <= '0;
      r_k          <= 2'd1;
      r_sp         <= STACK_BASE;
      r_spill_cnt  <= '0;
      r_need_spill <= 1'b0;
      r_need_fill  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (call_req || ret_req) begin
            if (w_call_ok) begin
              r_cwp        <= r_cwp + 2'd1;
              r_state      <= ST_WIN;
              r_need_spill <= (r_k == K_MAX);
              r_need_fill  <= 1'b0;
              if (r_k != K_MAX) r_k <= r_k + 2'd1;
            end else if (w_ret_ok) begin
              r_cwp        <= r_cwp - 2'd1;
              r_state      <= ST_WIN;
              r_need_spill <= 1'b0;
              r_need_fill  <= (r_k == 2'd1);
              if (r_k != 2'd1) r_k <= r_k - 2'd1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_WIN: begin
          if (r_need_spill)     r_state <= ST_SPILL0;
          else if (r_need_fill) r_state <= ST_FILL0;
          else                  r_state <= ST_IDLE;
        end
        ST_SPILL0: if (mem_ready) r_state <= ST_SPILL1;
        ST_SPILL1: begin
          if (mem_ready) begin
            r_sp        <= r_sp + 16'd2;
            r_spill_cnt <= r_spill_cnt + CW'(1);
            r_state     <= ST_IDLE;
          end
        end
        ST_FILL0: if (mem_ready) r_state <= ST_FILL1;
        ST_FILL1: begin
          if (mem_ready) begin
            r_sp        <= r_sp - 16'd2;
            r_spill_cnt <= r_spill_cnt - CW'(1);
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The accepting cycle itself already stalls, so a plain switch costs two cycles.
  assign stall      = ~w_idle | (w_call_ok | w_ret_ok);
  assign in_wnd     = r_cwp;
  assign change_wnd = (r_state == ST_WIN);
  assign err        = r_err;

  always_comb begin
    rf_rd_reg  = '0;
    rf_wr_reg  = '0;
    rf_wr_data = '0;
    rf_wr_en   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    case (r_state)
      ST_SPILL0: begin
        rf_rd_reg = SPILL_LO_REG;
        mem_we    = 1'b1;
        mem_addr  = r_sp;
        mem_wdata = rf_rd_data;
      end
      ST_SPILL1: begin
        rf_rd_reg = SPILL_LO_REG + 2'd1;
        mem_we    = 1'b1;
        mem_addr  = r_sp + 16'd1;
        mem_wdata = rf_rd_data;
      end
      ST_FILL0: begin
        mem_re     = 1'b1;
        mem_addr   = r_sp - 16'd2;
        rf_wr_en   = mem_ready;
        rf_wr_reg  = FILL_LO_REG;
        rf_wr_data = mem_ready ? mem_rdata : '0;
      end
      ST_FILL1: begin
        mem_re     = 1'b1;
        mem_addr   = r_sp - 16'd1;
        rf_wr_en   = mem_ready;
        rf_wr_reg  = FILL_LO_REG + 2'd1;
        rf_wr_data = mem_ready ? mem_rdata : '0;
      end
      default: ;
    endcase
  end

endmodule
